tib_parser: RTL and testbench

Terminal-input-buffer tokenizer directly upstream of the memory pool's FIND stage. It consumes a byte stream (UART/console) over a valid/ready handshake and skips whitespace. Each word is written into the pool's 8-bit memory at a fixed scratch region, null-terminated. A token descriptor (start address, length) is then offered to the FIND issuer, so the pool's string compare terminates on the stored 0x00.

---
 rtl/tib_parser.sv | 114 +++++++++++
 tb/tb_tib_parser.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tib_parser.sv
// Terminal-input-buffer tokenizer: splits a console byte stream into null-terminated
// words in the pool scratch region and offers a (start, length) descriptor to FIND.
//
// state | meaning
// SKIP  | discarding delimiters, waiting for the first character of a word
// TOKEN | storing word characters at TIB+len, excess beyond TMAX dropped
// TERM  | terminator write on the memory port, input stalled
// EMIT  | descriptor offered to FIND, held until tok_rdy
module tib_parser #(
    parameter int             DSZ  = 8,
    parameter int             ASZ  = 17,
    parameter logic [ASZ-1:0] TIB  = 'h1FF00,
    parameter int             TMAX = 31
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ci_vld,
    input  logic [DSZ-1:0]                ci,
    output logic                          ci_rdy,
    output logic                          we,
    output logic [ASZ-1:0]                a,
    output logic [DSZ-1:0]                vo,
    output logic                          tok_vld,
    input  logic                          tok_rdy,
    output logic [ASZ-1:0]                tok_a,
    output logic [$clog2(TMAX+1)-1:0]     tok_len,
    output logic                          ovf
);
    localparam int LW = $clog2(TMAX + 1);

    typedef enum logic [1:0] {SKIP, TOKEN, TERM, EMIT} state_t;

    state_t          state, state_n;
    logic [LW-1:0]   len, len_n;
    logic            ovf_n, we_n, accept, delim;
    logic [ASZ-1:0]  a_n;
    logic [DSZ-1:0]  vo_n;

    function automatic logic is_delim(input logic [DSZ-1:0] b);
        return (b == DSZ'('h20)) || (b == DSZ'('h09)) || (b == DSZ'('h0A)) ||
               (b == DSZ'('h0D)) || (b == DSZ'('h00));
    endfunction

    assign ci_rdy  = (state == SKIP) || (state == TOKEN);
    assign tok_vld = (state == EMIT);
    assign tok_len = tok_vld ? len : '0;
    assign tok_a   = TIB;
    assign accept  = ci_vld && ci_rdy;
    assign delim   = is_delim(ci);

    always_comb begin
        state_n = state;
        len_n   = len;
        ovf_n   = ovf;
        we_n    = 1'b0;
        a_n     = a;
        vo_n    = vo;
        case (state)
            SKIP: begin
                if (accept && !delim) begin
                    we_n    = 1'b1;
                    a_n     = TIB;
                    vo_n    = ci;
                    len_n   = LW'(1);
                    state_n = TOKEN;
                end
            end
            TOKEN: begin
                if (accept) begin
                    if (delim) begin
                        we_n    = 1'b1;
                        a_n     = TIB + ASZ'(len);
                        vo_n    = '0;
                        state_n = TERM;
                    end else if (len < LW'(TMAX)) begin
                        we_n  = 1'b1;
                        a_n   = TIB + ASZ'(len);
                        vo_n  = ci;
                        len_n = len + LW'(1);
                    end else begin
                        ovf_n = 1'b1;
                    end
                end
            end
            TERM: state_n = EMIT;
            EMIT: begin
                if (tok_rdy) begin
                    state_n = SKIP;
                    len_n   = '0;
                    ovf_n   = 1'b0;
                end
            end
            default: state_n = SKIP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= SKIP;
            len   <= '0;
            ovf   <= 1'b0;
            we    <= 1'b0;
            a     <= '0;
            vo    <= '0;
        end else begin
            state <= state_n;
            len   <= len_n;
            ovf   <= ovf_n;
            we    <= we_n;
            a     <= a_n;
            vo    <= vo_n;
        end
    end
endmodule

// File: tb/tb_tib_parser.sv
// Bench for tib_parser: directed and random byte streams checked against a word-splitting
// model of the input plus a shadow of the pool scratch memory.
module tb_tib_parser;
    localparam int DSZ = 8, ASZ = 17, TMAX = 31;
    localparam int LW = $clog2(TMAX + 1);
    localparam logic [ASZ-1:0] TIB = 17'h1FF00;
    localparam int LIMIT = 4000;

    logic clk = 1'b0, rst;
    logic ci_vld, ci_rdy, we, tok_vld, tok_rdy, ovf;
    logic [DSZ-1:0] ci, vo;
    logic [ASZ-1:0] a, tok_a;
    logic [LW-1:0] tok_len;

    int n_tests = 0, n_fail = 0;
    int wr_count = 0, bad_wr = 0;
    logic [7:0] mem [0:63];
    logic [7:0] stim[$];

    tib_parser #(.DSZ(DSZ), .ASZ(ASZ), .TIB(TIB), .TMAX(TMAX)) dut (
        .clk(clk), .rst(rst), .ci_vld(ci_vld), .ci(ci), .ci_rdy(ci_rdy),
        .we(we), .a(a), .vo(vo), .tok_vld(tok_vld), .tok_rdy(tok_rdy),
        .tok_a(tok_a), .tok_len(tok_len), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Shadow of the pool memory: whatever the pool would latch on each edge.
    always @(posedge clk) begin
        if (we) begin
            wr_count++;
            if (a >= TIB && int'(a - TIB) < 32) mem[int'(a - TIB)] = vo;
            else bad_wr++;
        end
    end

    function automatic bit is_delim(input logic [7:0] b);
        return b == 8'h20 || b == 8'h09 || b == 8'h0A || b == 8'h0D || b == 8'h00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stim.push_back(s[i]);
    endtask

    // vld_pct < 0 means ci_vld alternates every cycle.
    task automatic run(input int vld_pct, input int rdy_wait);
        int exp_len[$], exp_off[$];
        bit exp_ovf[$];
        logic [7:0] chars[$];
        int cur = 0, pos = 0, tok_i = 0, cyc = 0, end_cyc = -100, rdy_cnt = 0, wr_mark;
        bit in_tok = 0, prev_vld = 0, was_hs = 0, acc, hs;

        for (int i = 0; i < stim.size(); i++) begin
            if (is_delim(stim[i])) begin
                if (cur > 0) begin
                    int s = (cur > TMAX) ? TMAX : cur;
                    exp_off.push_back(chars.size() - s);
                    exp_len.push_back(s);
                    exp_ovf.push_back(cur > TMAX);
                    cur = 0;
                end
            end else begin
                if (cur < TMAX) chars.push_back(stim[i]);
                cur++;
            end
        end

        wr_mark = wr_count;
        while ((pos < stim.size() || tok_i < exp_len.size()) && cyc < LIMIT) begin
            @(negedge clk);
            cyc++;
            if (was_hs) begin
                check("hs_ovf_clear", ovf, 0);
                check("hs_ci_rdy", ci_rdy, 1);
                check("hs_tok_vld", tok_vld, 0);
                was_hs = 0;
            end
            if (tok_vld && !prev_vld) begin
                if (tok_i < exp_len.size()) begin
                    check("vld_latency", cyc, end_cyc + 2);
                    check("tok_len", tok_len, exp_len[tok_i]);
                    check("ovf", ovf, exp_ovf[tok_i]);
                    check("tok_a", tok_a, TIB);
                    check("n_writes", wr_count - wr_mark, exp_len[tok_i] + 1);
                    for (int j = 0; j < exp_len[tok_i]; j++)
                        check("mem_byte", mem[j], chars[exp_off[tok_i] + j]);
                    check("mem_term", mem[exp_len[tok_i]], 0);
                end else begin
                    check("extra_tok", tok_i, exp_len.size());
                end
                wr_mark = wr_count;
            end
            if (tok_vld) check("emit_ci_rdy", ci_rdy, 0);
            prev_vld = tok_vld;

            ci_vld  = (pos < stim.size()) &&
                      ((vld_pct < 0) ? (cyc % 2 == 1) : ($urandom_range(99) < vld_pct));
            ci      = (pos < stim.size()) ? stim[pos] : 8'($urandom);
            tok_rdy = tok_vld ? (rdy_cnt >= rdy_wait) : 1'($urandom_range(1));
            acc     = ci_vld && ci_rdy;
            hs      = tok_vld && tok_rdy;
            @(posedge clk);
            if (acc) begin
                if (is_delim(stim[pos])) begin
                    if (in_tok) end_cyc = cyc;
                    in_tok = 0;
                end else begin
                    in_tok = 1;
                end
                pos++;
            end
            if (hs) begin
                tok_i++;
                rdy_cnt = 0;
                was_hs = 1;
            end else if (tok_vld) begin
                rdy_cnt++;
            end
        end
        check("timeout", cyc < LIMIT, 1);
        @(negedge clk);
        ci_vld  = 1'b0;
        tok_rdy = 1'b0;
        stim.delete();
    endtask

    initial begin
        rst = 1'b1; ci_vld = 1'b0; ci = '0; tok_rdy = 1'b0;
        #1;
        check("rst_ci_rdy", ci_rdy, 1);
        check("rst_we", we, 0);
        check("rst_a", a, 0);
        check("rst_vo", vo, 0);
        check("rst_tok_vld", tok_vld, 0);
        check("rst_tok_len", tok_len, 0);
        check("rst_ovf", ovf, 0);
        check("rst_tok_a", tok_a, TIB);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        add_str("DUP ");             run(100, 0);
        add_str("  \t\r\nSWAP\n");   run(100, 0);
        for (int i = 0; i < 40; i++) stim.push_back("A");
        add_str(" ");                run(100, 0);
        add_str("OVER ROT ");        run(100, 5);
        add_str("X"); stim.push_back(8'h00); run(-1, 0);

        // Reset mid-token: partial "DR" is discarded.
        @(negedge clk); ci_vld = 1'b1; ci = "D";
        @(posedge clk);
        @(negedge clk); ci = "R";
        @(posedge clk);
        #2 rst = 1'b1; ci_vld = 1'b0;
        #1;
        check("mid_rst_we", we, 0);
        check("mid_rst_tok_vld", tok_vld, 0);
        check("mid_rst_ci_rdy", ci_rdy, 1);
        check("mid_rst_a", a, 0);
        @(negedge clk); rst = 1'b0;
        add_str("1+ ");              run(100, 0);

        for (int r = 0; r < 8; r++) begin
            int nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                int nd = $urandom_range(0, 3);
                int wl = ($urandom_range(4) == 0) ? $urandom_range(28, 40) : $urandom_range(1, 8);
                for (int d = 0; d < nd; d++) begin
                    case ($urandom_range(4))
                        0: stim.push_back(8'h20);
                        1: stim.push_back(8'h09);
                        2: stim.push_back(8'h0A);
                        3: stim.push_back(8'h0D);
                        default: stim.push_back(8'h00);
                    endcase
                end
                for (int c = 0; c < wl; c++) stim.push_back(8'($urandom_range(8'h21, 8'hFF)));
                stim.push_back(8'h20);
            end
            run($urandom_range(30, 100), $urandom_range(0, 3));
        end

        check("bad_wr_addr", bad_wr, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
